seq_alu: RTL

- Parametrised, registered 8-operation ALU with a valid/ready handshake on input and output.
- Add, sub, shift and compare complete in one cycle. Divide and modulo use an iterative restoring divider, one quotient bit per cycle.
- Sits between an operand source and a result consumer. Replaces purely combinational ALU use where timing closure or back-pressure matters.

---
 rtl/seq_alu.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Registered 8-op ALU with valid/ready handshakes. Div/mod use an iterative restoring divider.
// Define SEQ_ALU_ERR_EN to add an err output that flags divide-by-zero and shl overflow.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out
`ifdef SEQ_ALU_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_GT   = 3'b111;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             mod_q, mod_d;

  logic             accept;
  logic             start_div;
  logic [WIDTH:0]   a_x, b_x;
  logic [WIDTH:0]   single_res;
  logic [WIDTH:0]   shifted, trial, rem_new;
  logic             step_ge;
  logic [WIDTH-1:0] quo_new;

  assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign accept    = in_valid & in_ready;
  assign start_div = ((sel == OP_DIV) || (sel == OP_MOD)) && (b != '0);
  assign a_x       = {1'b0, a};
  assign b_x       = {1'b0, b};

  always_comb begin
    single_res = '0;
    case (sel)
      OP_PASS: single_res = a_x;
      OP_ADD:  single_res = a_x + b_x;
      OP_SUB:  single_res = a_x - b_x;
      OP_DIV:  single_res = {1'b0, {WIDTH{1'b1}}};
      OP_MOD:  single_res = a_x;
      OP_SHL:  single_res = a_x << b;
      OP_SHR:  single_res = a_x >> b;
      OP_GT:   single_res = {{WIDTH{1'b0}}, (a > b)};
      default: single_res = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    step_ge = (shifted >= {1'b0, dvs_q});
    rem_new = step_ge ? trial : shifted;
    quo_new = {quo_q[WIDTH-2:0], step_ge};
  end

`ifdef SEQ_ALU_ERR_EN
  logic           err_q, err_d;
  logic           single_err;
  logic [WIDTH:0] shl_room;
  logic           shl_lost;
  localparam logic [WIDTH:0] W1 = (WIDTH + 1)'(WIDTH + 1);

  // shl overflows when any set bit of a would be shifted past the result MSB.
  always_comb begin
    shl_room = W1 - b_x;
    if (b_x >= W1) shl_lost = (a != '0);
    else           shl_lost = ((a_x >> shl_room) != '0);
    single_err = 1'b0;
    if (sel == OP_DIV || sel == OP_MOD) single_err = (b == '0);
    else if (sel == OP_SHL)             single_err = shl_lost;
  end
  assign err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    mod_d   = mod_q;
`ifdef SEQ_ALU_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      DIV: begin
        rem_d = rem_new;
        quo_d = quo_new;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          out_d   = mod_q ? rem_new : {1'b0, quo_new};
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef SEQ_ALU_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: ;
    endcase
    // An accept is only possible from IDLE or a draining DONE; it overrides both.
    if (accept) begin
      if (start_div) begin
        rem_d   = '0;
        quo_d   = a;
        dvs_d   = b;
        mod_d   = (sel == OP_MOD);
        cnt_d   = '0;
        state_d = DIV;
`ifdef SEQ_ALU_ERR_EN
        err_d   = 1'b0;
`endif
      end else begin
        out_d   = single_res;
        state_d = DONE;
`ifdef SEQ_ALU_ERR_EN
        err_d   = single_err;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      mod_q   <= 1'b0;
`ifdef SEQ_ALU_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      mod_q   <= mod_d;
`ifdef SEQ_ALU_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule
